// File: rtl/som_sub_pkg.sv
// Shared definitions for the pipelined add/subtract block: op encodings,
// flag bit positions and the stage-count helpers used at elaboration time.
package som_sub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    // Bit positions inside the registered flag vector.
    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

    // One pipeline rank per CHUNK-bit slice of the operands.
    function automatic int som_sub_stages(input int n, input int chunk);
        return n / chunk;
    endfunction

    // The operand width must split into whole chunks, at least one of them.
    function automatic bit som_sub_width_ok(input int n, input int chunk);
        return (chunk > 0) && (n >= chunk) && ((n % chunk) == 0);
    endfunction

endpackage

// File: rtl/som_sub_pipe_if.sv
// Operand/result handshake bundle for som_sub_pipe. The slave modport is the
// arithmetic block; the master modport is the producer/consumer side.
interface som_sub_pipe_if #(
    parameter int N     = 64,
    parameter int TAG_W = 5
);
    import som_sub_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     n1;
    logic [N-1:0]     n2;
    op_e              op;
    logic             cin;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic             out_ready;
    logic [N:0]       res;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, n1, n2, op, cin, tag_in, out_ready,
        input  in_ready, out_valid, res, flag_c, flag_v, flag_z, flag_n, tag_out
    );

    modport slave (
        input  in_valid, n1, n2, op, cin, tag_in, out_ready,
        output in_ready, out_valid, res, flag_c, flag_v, flag_z, flag_n, tag_out
    );

endinterface

// File: rtl/addsub_chunk.sv
// One carry-chained slice of the wide adder: W-bit add with carry in/out.
module addsub_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Widen by one bit so the carry out falls out of the same addition.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/som_sub_pipe.sv
// Pipelined N-bit add/subtract with carry-in ops, C/V/Z/N flags and a
// passthrough tag. Rank k adds chunk k; higher operand chunks ride along
// unadded, finished low chunks are carried forward, and the last rank is the
// registered output. The whole pipe advances together unless the output is
// held by the consumer.
module som_sub_pipe
    import som_sub_pkg::*;
#(
    parameter int N     = 64,
    parameter int CHUNK = 16,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    som_sub_pipe_if.slave bus
);

    localparam int STAGES = som_sub_stages(N, CHUNK);
    localparam int L      = STAGES - 1;

    typedef logic [N-1:0] word_t;

    if (!som_sub_width_ok(N, CHUNK)) begin : g_bad_width
        $error("som_sub_pipe: N must be a positive multiple of CHUNK");
    end

    // Per-rank registers; a_q/b_q hold the full operands so the chunks not
    // yet added and the sign bits stay with their transaction.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    word_t             a_q   [STAGES];
    word_t             b_q   [STAGES];
    word_t             s_q   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [NUM_FLAGS-1:0] flags_q;

    // What each rank would capture on an advancing edge.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    word_t             src_a   [STAGES];
    word_t             src_b   [STAGES];
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [CHUNK-1:0]  csum    [STAGES];
    logic [STAGES-1:0] ccout;
    word_t             nxt_s   [STAGES];

    logic                 advance;
    logic                 accept;
    word_t                eff_b;
    logic                 c0;
    logic [NUM_FLAGS-1:0] flags_d;

    assign advance      = !v_q[L] || bus.out_ready;
    assign bus.in_ready = advance && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;

    // Subtract ops invert n2; ADD/SUB force the carry-in, ADC/SBC take cin.
    always_comb begin
        eff_b = bus.n2;
        c0    = 1'b0;
        case (bus.op)
            OP_ADD: begin eff_b = bus.n2;  c0 = 1'b0;    end
            OP_SUB: begin eff_b = ~bus.n2; c0 = 1'b1;    end
            OP_ADC: begin eff_b = bus.n2;  c0 = bus.cin; end
            OP_SBC: begin eff_b = ~bus.n2; c0 = bus.cin; end
            default: begin eff_b = bus.n2; c0 = 1'b0;    end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src_v[0]   = accept;
            assign src_c[0]   = c0;
            assign src_a[0]   = bus.n1;
            assign src_b[0]   = eff_b;
            assign src_tag[0] = bus.tag_in;
            assign nxt_s[0]   = word_t'(csum[0]);
        end else begin : g_next
            assign src_v[k]   = v_q[k-1];
            assign src_c[k]   = c_q[k-1];
            assign src_a[k]   = a_q[k-1];
            assign src_b[k]   = b_q[k-1];
            assign src_tag[k] = tag_q[k-1];
            // Low chunks of s_q[k-1] are already final; its upper bits are zero.
            assign nxt_s[k]   = s_q[k-1] | (word_t'(csum[k]) << (k * CHUNK));
        end

        addsub_chunk #(.W(CHUNK)) u_chunk (
            .a    (src_a[k][k*CHUNK +: CHUNK]),
            .b    (src_b[k][k*CHUNK +: CHUNK]),
            .cin  (src_c[k]),
            .sum  (csum[k]),
            .cout (ccout[k])
        );
    end

    // Flags come from the fully assembled sum entering the output rank.
    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_C] = ccout[L];
        flags_d[FLAG_Z] = (nxt_s[L] == '0);
        flags_d[FLAG_N] = nxt_s[L][N-1];
        flags_d[FLAG_V] = (src_a[L][N-1] == src_b[L][N-1]) &&
                          (nxt_s[L][N-1] != src_a[L][N-1]);
    end

    // Shift every rank forward on advance; data only loads behind a valid
    // source so bubbles leave the previous contents untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k]   <= src_a[k];
                    b_q[k]   <= src_b[k];
                    s_q[k]   <= nxt_s[k];
                    c_q[k]   <= ccout[k];
                    tag_q[k] <= src_tag[k];
                end
            end
            if (src_v[L]) begin
                flags_q <= flags_d;
            end
        end
    end

    assign bus.out_valid = v_q[L];
    assign bus.res       = {c_q[L], s_q[L]};
    assign bus.flag_c    = flags_q[FLAG_C];
    assign bus.flag_v    = flags_q[FLAG_V];
    assign bus.flag_z    = flags_q[FLAG_Z];
    assign bus.flag_n    = flags_q[FLAG_N];
    assign bus.tag_out   = tag_q[L];

endmodule

// File: tb/tb_som_sub_pipe.sv
// Scoreboard bench for som_sub_pipe: the driver pushes hand-computed
// expectations when a transfer is accepted, the monitor pops and compares on
// every output transfer.
module tb_som_sub_pipe;
    import som_sub_pkg::*;

    localparam int N      = 64;
    localparam int CHUNK  = 16;
    localparam int TAG_W  = 5;
    localparam int STAGES = N / CHUNK;

    typedef logic [N:0] rw_t;

    typedef struct {
        op_e          op;
        logic [N-1:0] n1;
        logic [N-1:0] n2;
        logic         cin;
        logic [N:0]   res;
        logic [3:0]   f;     // {c, v, z, n}
    } vec_t;

    typedef struct {
        logic [N:0]       res;
        logic [3:0]       f;
        logic [TAG_W-1:0] tag;
        bit               lat;
        int               acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t vt [12];
    exp_t sbq [$];

    som_sub_pipe_if #(.N(N), .TAG_W(TAG_W)) bus ();

    som_sub_pipe #(.N(N), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input rw_t act, input rw_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input op_e op, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic c, input logic [N:0] r, input logic [3:0] f);
        vec_t v;
        v.op = op; v.n1 = a; v.n2 = b; v.cin = c; v.res = r; v.f = f;
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int i, input logic [TAG_W-1:0] tag, input bit lat);
        exp_t e;
        int   guard = 0;
        bus.n1       = vt[i].n1;
        bus.n2       = vt[i].n2;
        bus.op       = vt[i].op;
        bus.cin      = vt[i].cin;
        bus.tag_in   = tag;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: vector %0d never accepted", i);
        end else begin
            e.res = vt[i].res; e.f = vt[i].f; e.tag = tag; e.lat = lat; e.acc = cyc + 1;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain_pending", rw_t'(sbq.size()), rw_t'(0));
    endtask

    // Monitor: every output transfer must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out: res %h tag %0d with empty scoreboard", bus.res, bus.tag_out);
                end else begin
                    e = sbq.pop_front();
                    chk("res", bus.res, e.res);
                    chk("flags", rw_t'({bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}), rw_t'(e.f));
                    chk("tag", rw_t'(bus.tag_out), rw_t'(e.tag));
                    if (e.lat) chk("latency", rw_t'(cyc - e.acc), rw_t'(STAGES - 1));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(OP_SUB, 64'd5, 64'd3, 1'b0, 65'h1_0000_0000_0000_0002, 4'b1000);
        vt[1]  = mk(OP_SUB, 64'd3, 64'd5, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFE, 4'b0001);
        vt[2]  = mk(OP_SUB, 64'h1234, 64'h1234, 1'b0, 65'h1_0000_0000_0000_0000, 4'b1010);
        vt[3]  = mk(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h0_8000_0000_0000_0000, 4'b0101);
        vt[4]  = mk(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'h1_0000_0000_0000_0000, 4'b1010);
        vt[5]  = mk(OP_ADC, 64'd0, 64'd0, 1'b1, 65'h0_0000_0000_0000_0001, 4'b0000);
        vt[6]  = mk(OP_ADD, 64'hFFFF, 64'd1, 1'b0, 65'h0_0000_0000_0001_0000, 4'b0000);
        vt[7]  = mk(OP_SBC, 64'd10, 64'd3, 1'b0, 65'h1_0000_0000_0000_0006, 4'b1000);
        vt[8]  = mk(OP_SBC, 64'd10, 64'd3, 1'b1, 65'h1_0000_0000_0000_0007, 4'b1000);
        vt[9]  = mk(OP_ADC, 64'hFFFF_FFFF, 64'd1, 1'b1, 65'h0_0000_0001_0000_0001, 4'b0000);
        vt[10] = mk(OP_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                    65'h1_0000_0000_0000_0000, 4'b1110);
        vt[11] = mk(OP_SBC, 64'd0, 64'd0, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFF, 4'b0001);

        bus.in_valid  = 1'b0;
        bus.n1        = '0;
        bus.n2        = '0;
        bus.op        = OP_ADD;
        bus.cin       = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", rw_t'(bus.out_valid), rw_t'(0));
        chk("rst_res", bus.res, rw_t'(0));
        chk("rst_flags", rw_t'({bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}), rw_t'(0));
        chk("rst_tag", rw_t'(bus.tag_out), rw_t'(0));
        chk("rst_in_ready", rw_t'(bus.in_ready), rw_t'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single SUB 5-3, tag 7.
        send(0, 5'd7, 1'b1);
        drain();

        // Eight back-to-back transfers, tags 0..7.
        for (int i = 0; i < 8; i++) send(i, 5'(i), 1'b1);
        drain();

        // Transfers separated by a bubble.
        send(9, 5'd12, 1'b1);
        @(negedge clk);
        send(10, 5'd13, 1'b1);
        drain();

        // Output stall for three cycles with results queued behind.
        send(8, 5'd8, 1'b0);
        send(9, 5'd9, 1'b0);
        send(10, 5'd10, 1'b0);
        send(11, 5'd11, 1'b0);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_out_valid", rw_t'(bus.out_valid), rw_t'(1));
            chk("stall_in_ready", rw_t'(bus.in_ready), rw_t'(0));
            if (sbq.size() > 0) begin
                chk("stall_res_frozen", bus.res, sbq[0].res);
                chk("stall_tag_frozen", rw_t'(bus.tag_out), rw_t'(sbq[0].tag));
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        drain();

        // Reset with three transactions in flight.
        send(0, 5'd20, 1'b0);
        send(1, 5'd21, 1'b0);
        send(2, 5'd22, 1'b0);
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", rw_t'(bus.out_valid), rw_t'(0));
        chk("mid_rst_res", bus.res, rw_t'(0));
        chk("mid_rst_flags", rw_t'({bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}), rw_t'(0));
        chk("mid_rst_tag", rw_t'(bus.tag_out), rw_t'(0));
        chk("mid_rst_in_ready", rw_t'(bus.in_ready), rw_t'(0));
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(6, 5'd5, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/som_sub_pipe.md
# som_sub_pipe

Parametrised, pipelined successor of the combinational adder/subtractor. It splits an N-bit add/subtract into CHUNK-bit carry-chained stages, adds carry-in ops (ADC/SBC), produces C/V/Z/N flags, and passes a tag through. Valid/ready handshakes on both sides let it sit between the RISC-V execute-stage operand mux and writeback, or serve wide multi-word arithmetic, at one result per cycle.

## Interface
- N, 64: operand width; must be a multiple of CHUNK.
- CHUNK, 16: bits added per pipeline stage; STAGES = N/CHUNK, STAGES ≥ 1.
- TAG_W, 5: width of the passthrough tag (e.g. destination register index).
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- n1  in  N  first operand.
- n2  in  N  second operand.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- cin  in  1  carry-in for ADC/SBC; ignored for ADD/SUB.
- tag_in  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- res  out  N+1  res[N-1:0] sum/difference, res[N] carry-out.
- flag_c, flag_v, flag_z, flag_n  out  1 each  carry, signed overflow, zero, negative.
- tag_out  out  TAG_W  tag of the current result.

## Operation
- Effective operand b = n2 for ADD/ADC, ~n2 for SUB/SBC. Carry-in c0: ADD 0, SUB 1, ADC cin, SBC cin. Under SBC, cin = 1 means no borrow.
- res = n1 + b + c0, computed modulo 2^(N+1). res[N] is the carry out of bit N-1. For SUB, res[N] = 1 means no borrow (n1 ≥ n2 unsigned), including n2 = 0.
- flag_c = res[N]; flag_n = res[N-1]; flag_z = (res[N-1:0] == 0).
- flag_v = (n1[N-1] == b[N-1]) && (res[N-1] != n1[N-1]).
- Stage k (0..STAGES-1) adds chunk k of n1 and b with the carry registered by stage k-1; stage 0 uses c0.
  - Not-yet-added higher chunks travel skewed alongside, in registers.
  - Completed lower chunks are carried forward.
  - Operand sign bits and the tag travel with the transaction so flags can be computed in the last stage.
- Each rank has a valid bit. The pipeline advances as a whole when advance = !out_valid || out_ready; otherwise every rank holds.
- in_ready = advance && rst_n. While stalled, holding in_valid and operands is the producer's responsibility; held operands are not sampled.
- Bubbles propagate as invalid ranks and are not squeezed out. Only a stall at the output freezes the pipeline.

## Timing
- Reset (rst_n low at a rising edge): all valid bits 0 and all data registers 0 on that edge. Thereafter out_valid = 0, res = 0, all flags 0, tag_out = 0, and in_ready = 0 while rst_n is low.
- Reset mid-operation discards all in-flight transactions; nothing is output for them.
- Latency: a transfer accepted at edge e appears with out_valid = 1 immediately after edge e+STAGES-1, provided no stall occurs. Each stall cycle adds exactly one cycle.
- With STAGES = 1, out_valid rises right after the accepting edge.
- Throughput: one transaction per cycle while out_ready = 1.
- Output is registered. res, flags and tag_out stay stable while out_valid && !out_ready.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required at full rate.
- Order is strictly FIFO, and the tag matches its operands.

## Structure
- Shared package/header som_sub_pkg:
  - op encodings OP_ADD, OP_SUB, OP_ADC, OP_SBC;
  - flag bit indices;
  - the STAGES = N/CHUNK derivation;
  - an elaboration check that N % CHUNK == 0.
- Sub-module addsub_chunk: combinational CHUNK-bit adder with inputs a, b, cin and outputs sum, cout. STAGES instances sit in a generate loop.
- Top level holds the skew/valid registers, the advance logic and the final-stage flag logic.

## Test plan
- Defaults N=64, CHUNK=16, out_ready=1. SUB n1=5, n2=3, tag=7 → after 4 cycles: res[63:0]=2, res[64]=1, c=1, z=0, n=0, v=0, tag_out=7.
- SUB n1=3, n2=5 → res[63:0]=0xFFFF_FFFF_FFFF_FFFE, c=0, n=1, v=0. SUB n1=n2=0x1234 → z=1, c=1.
- ADD n1=0x7FFF_FFFF_FFFF_FFFF, n2=1 → res[63:0]=0x8000_0000_0000_0000, v=1, n=1, c=0. ADD all-ones + 1 → res=1<<64, z=1, c=1. ADC 0+0 with cin=1 → res=1.
- Back-to-back: 8 consecutive transfers, tags 0..7 → 8 results on consecutive cycles, in order, each correct. Chunk-boundary carry check: ADD 0xFFFF + 1 → 0x10000.
- Stall: hold out_ready=0 for 3 cycles while a result is valid → in_ready=0, outputs frozen, no loss or duplication. Release → remaining results follow in order.
- Reset: assert rst_n=0 for 1 cycle with 3 transactions in flight → all outputs 0 and no stale result afterwards. A new transaction after reset completes with 4-cycle latency.
